// File: rtl/chimera_cluster_pwr_ctrl.sv
// chimera_cluster_pwr_ctrl
// Register-programmed power sequencer for the Chimera clusters. Each cluster
// has its own FSM ordering clock enable, reset release, AXI isolation and
// drain, so clusters can be switched at runtime without cutting off traffic.
module chimera_cluster_pwr_ctrl #(
    parameter int unsigned NumClusters  = 5,
    parameter int unsigned AddrWidth    = 32,
    parameter int unsigned DefaultDelay = 8,
    parameter int unsigned DrainTimeout = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   reg_valid_i,
    input  logic                   reg_write_i,
    input  logic [AddrWidth-1:0]   reg_addr_i,
    input  logic [31:0]            reg_wdata_i,
    input  logic [3:0]             reg_wstrb_i,
    output logic                   reg_ready_o,
    output logic [31:0]            reg_rdata_o,
    output logic                   reg_error_o,
    input  logic [NumClusters-1:0] cluster_idle_i,
    output logic [NumClusters-1:0] cluster_clk_en_o,
    output logic [NumClusters-1:0] cluster_rst_no,
    output logic [NumClusters-1:0] cluster_iso_o
);

    // One counter serves both the sequencing delay and the drain timeout,
    // so it must be wide enough for whichever is larger.
    localparam int unsigned ToBits = $clog2(DrainTimeout + 1);
    localparam int unsigned CntW   = (ToBits > 8) ? ToBits : 8;

    localparam logic [2:0] OffEnReq    = 3'd0;
    localparam logic [2:0] OffStatus   = 3'd1;
    localparam logic [2:0] OffBusy     = 3'd2;
    localparam logic [2:0] OffSeqDelay = 3'd3;
    localparam logic [2:0] OffTimeout  = 3'd4;

    typedef enum logic [2:0] {
        StOff,
        StClkOn,
        StRun,
        StDrain,
        StReset
    } state_t;

    logic [2:0]             reg_offset;
    logic [31:0]            wbyte_mask;
    logic [NumClusters-1:0] en_req_reg;
    logic [NumClusters-1:0] timeout_reg;
    logic [7:0]             seq_delay_reg;
    logic [NumClusters-1:0] run_vec;
    logic [NumClusters-1:0] busy_vec;
    logic [NumClusters-1:0] timeout_set;
    logic [NumClusters-1:0] timeout_clr;
    logic [CntW-1:0]        delay_load;
    logic [CntW-1:0]        drain_load;
    logic                   wr_en_req;
    logic                   wr_seq_delay;
    logic                   wr_timeout;
    logic                   unused_addr;
    logic                   unused_wdata;

    // Only the word offset is decoded; the remaining address bits are ignored.
    assign reg_offset   = reg_addr_i[4:2];
    assign unused_addr  = ^reg_addr_i;
    assign unused_wdata = ^reg_wdata_i;

    for (genvar gi = 0; gi < 4; gi++) begin : g_wbyte
        assign wbyte_mask[8*gi +: 8] = {8{reg_wstrb_i[gi]}};
    end

    assign wr_en_req    = reg_valid_i && reg_write_i && (reg_offset == OffEnReq);
    assign wr_seq_delay = reg_valid_i && reg_write_i && (reg_offset == OffSeqDelay)
                          && reg_wstrb_i[0];
    assign wr_timeout   = reg_valid_i && reg_write_i && (reg_offset == OffTimeout);
    assign timeout_clr  = wr_timeout ? (reg_wdata_i[NumClusters-1:0] & wbyte_mask[NumClusters-1:0])
                                     : '0;

    // A programmed delay of zero is stretched to one cycle.
    assign delay_load = (seq_delay_reg == 8'd0) ? CntW'(1) : CntW'(seq_delay_reg);
    assign drain_load = CntW'(DrainTimeout);

    // Configuration registers; a timeout event wins over a same-cycle clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_req_reg    <= '0;
            timeout_reg   <= '0;
            seq_delay_reg <= 8'(DefaultDelay);
        end else begin
            if (wr_en_req) begin
                en_req_reg <= (en_req_reg & ~wbyte_mask[NumClusters-1:0])
                            | (reg_wdata_i[NumClusters-1:0] & wbyte_mask[NumClusters-1:0]);
            end
            if (wr_seq_delay) begin
                seq_delay_reg <= reg_wdata_i[7:0];
            end
            timeout_reg <= (timeout_reg & ~timeout_clr) | timeout_set;
        end
    end

    // Combinational read/error response in the request cycle.
    always_comb begin
        reg_rdata_o = '0;
        reg_error_o = 1'b0;
        if (reg_valid_i) begin
            case (reg_offset)
                OffEnReq:    if (!reg_write_i) reg_rdata_o = 32'(en_req_reg);
                OffStatus:   if (reg_write_i) reg_error_o = 1'b1;
                             else             reg_rdata_o = 32'(run_vec);
                OffBusy:     if (reg_write_i) reg_error_o = 1'b1;
                             else             reg_rdata_o = 32'(busy_vec);
                OffSeqDelay: if (!reg_write_i) reg_rdata_o = {24'd0, seq_delay_reg};
                OffTimeout:  if (!reg_write_i) reg_rdata_o = 32'(timeout_reg);
                default:     reg_error_o = 1'b1;
            endcase
        end
    end

    assign reg_ready_o = reg_valid_i;

    for (genvar gi = 0; gi < NumClusters; gi++) begin : g_cluster
        state_t          state_reg;
        state_t          state_next;
        logic [CntW-1:0] cnt_reg;
        logic [CntW-1:0] cnt_next;
        logic            to_hit;
        logic            clk_en_reg;
        logic            rst_n_reg;
        logic            iso_reg;

        // Next-state logic: sequences always run to completion before the
        // request bit is looked at again.
        always_comb begin
            state_next = state_reg;
            cnt_next   = cnt_reg;
            to_hit     = 1'b0;
            case (state_reg)
                StOff: begin
                    if (en_req_reg[gi]) begin
                        state_next = StClkOn;
                        cnt_next   = delay_load;
                    end
                end
                StClkOn: begin
                    cnt_next = cnt_reg - CntW'(1);
                    if (cnt_reg <= CntW'(1)) state_next = StRun;
                end
                StRun: begin
                    if (!en_req_reg[gi]) begin
                        state_next = StDrain;
                        cnt_next   = drain_load;
                    end
                end
                StDrain: begin
                    cnt_next = cnt_reg - CntW'(1);
                    if (cluster_idle_i[gi]) begin
                        state_next = StReset;
                        cnt_next   = delay_load;
                    end else if (cnt_reg <= CntW'(1)) begin
                        to_hit     = 1'b1;
                        state_next = StReset;
                        cnt_next   = delay_load;
                    end
                end
                StReset: begin
                    cnt_next = cnt_reg - CntW'(1);
                    if (cnt_reg <= CntW'(1)) state_next = StOff;
                end
                default: begin
                    state_next = StOff;
                    cnt_next   = '0;
                end
            endcase
        end

        // State, counter and output flops; outputs are decoded from the next
        // state so they change on the same edge as the state itself.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_reg  <= StOff;
                cnt_reg    <= '0;
                clk_en_reg <= 1'b0;
                rst_n_reg  <= 1'b0;
                iso_reg    <= 1'b1;
            end else begin
                state_reg  <= state_next;
                cnt_reg    <= cnt_next;
                clk_en_reg <= (state_next != StOff);
                rst_n_reg  <= (state_next == StRun) || (state_next == StDrain);
                iso_reg    <= (state_next != StRun);
            end
        end

        assign cluster_clk_en_o[gi] = clk_en_reg;
        assign cluster_rst_no[gi]   = rst_n_reg;
        assign cluster_iso_o[gi]    = iso_reg;
        assign run_vec[gi]          = (state_reg == StRun);
        assign busy_vec[gi]         = (state_reg != StOff) && (state_reg != StRun);
        assign timeout_set[gi]      = to_hit;
    end

endmodule

// File: tb/tb_chimera_cluster_pwr_ctrl.sv
// Bench for chimera_cluster_pwr_ctrl: directed timing checks with literal
// expectations, then randomized traffic compared every cycle against a
// timestamp-based model of the cluster power phases.
module tb_chimera_cluster_pwr_ctrl;

    localparam int N  = 5;
    localparam int DT = 16;
    localparam int DD = 8;

    localparam int P_OFF   = 0;
    localparam int P_UP    = 1;
    localparam int P_RUN   = 2;
    localparam int P_DRAIN = 3;
    localparam int P_DOWN  = 4;

    logic          clk_i;
    logic          rst_ni;
    logic          reg_valid_i;
    logic          reg_write_i;
    logic [31:0]   reg_addr_i;
    logic [31:0]   reg_wdata_i;
    logic [3:0]    reg_wstrb_i;
    logic          reg_ready_o;
    logic [31:0]   reg_rdata_o;
    logic          reg_error_o;
    logic [N-1:0]  cluster_idle_i;
    logic [N-1:0]  cluster_clk_en_o;
    logic [N-1:0]  cluster_rst_no;
    logic [N-1:0]  cluster_iso_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // model state: phase per cluster and the absolute edge at which it ends
    int           phase    [N];
    int           deadline [N];
    logic [N-1:0] m_en;
    logic [N-1:0] m_to;
    logic [7:0]   m_delay;

    chimera_cluster_pwr_ctrl #(
        .NumClusters (N),
        .AddrWidth   (32),
        .DefaultDelay(DD),
        .DrainTimeout(DT)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .reg_valid_i     (reg_valid_i),
        .reg_write_i     (reg_write_i),
        .reg_addr_i      (reg_addr_i),
        .reg_wdata_i     (reg_wdata_i),
        .reg_wstrb_i     (reg_wstrb_i),
        .reg_ready_o     (reg_ready_o),
        .reg_rdata_o     (reg_rdata_o),
        .reg_error_o     (reg_error_o),
        .cluster_idle_i  (cluster_idle_i),
        .cluster_clk_en_o(cluster_clk_en_o),
        .cluster_rst_no  (cluster_rst_no),
        .cluster_iso_o   (cluster_iso_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: phases with absolute deadlines, then register writes.
    always @(posedge clk_i or negedge rst_ni) begin
        int           d;
        logic [N-1:0] set_to;
        if (!rst_ni) begin
            for (int i = 0; i < N; i++) begin
                phase[i]    = P_OFF;
                deadline[i] = 0;
            end
            m_en    = '0;
            m_to    = '0;
            m_delay = 8'(DD);
        end else begin
            cyc++;
            d      = (m_delay == 8'd0) ? 1 : int'(m_delay);
            set_to = '0;
            for (int i = 0; i < N; i++) begin
                case (phase[i])
                    P_OFF: if (m_en[i]) begin
                        phase[i] = P_UP; deadline[i] = cyc + d;
                    end
                    P_UP: if (cyc >= deadline[i]) phase[i] = P_RUN;
                    P_RUN: if (!m_en[i]) begin
                        phase[i] = P_DRAIN; deadline[i] = cyc + DT;
                    end
                    P_DRAIN: begin
                        if (cluster_idle_i[i]) begin
                            phase[i] = P_DOWN; deadline[i] = cyc + d;
                        end else if (cyc >= deadline[i]) begin
                            set_to[i] = 1'b1;
                            phase[i] = P_DOWN; deadline[i] = cyc + d;
                        end
                    end
                    default: if (cyc >= deadline[i]) phase[i] = P_OFF;
                endcase
            end
            if (reg_valid_i && reg_write_i) begin
                case (reg_addr_i[4:2])
                    3'd0: for (int i = 0; i < N; i++)
                              if (reg_wstrb_i[i/8]) m_en[i] = reg_wdata_i[i];
                    3'd3: if (reg_wstrb_i[0]) m_delay = reg_wdata_i[7:0];
                    3'd4: for (int i = 0; i < N; i++)
                              if (reg_wstrb_i[i/8] && reg_wdata_i[i]) m_to[i] = 1'b0;
                    default: ;
                endcase
            end
            m_to = m_to | set_to;
        end
    end

    // Compare process: every cycle, outputs and bus response against the model.
    always @(negedge clk_i) begin
        logic [N-1:0] e_clk, e_rst, e_iso, e_run, e_busy;
        logic [31:0]  e_rd;
        logic         e_err;
        int           off;
        for (int i = 0; i < N; i++) begin
            e_clk[i]  = (phase[i] != P_OFF);
            e_rst[i]  = (phase[i] == P_RUN) || (phase[i] == P_DRAIN);
            e_iso[i]  = (phase[i] != P_RUN);
            e_run[i]  = (phase[i] == P_RUN);
            e_busy[i] = (phase[i] == P_UP) || (phase[i] == P_DRAIN) || (phase[i] == P_DOWN);
        end
        chk("clk_en", 32'(cluster_clk_en_o), 32'(e_clk));
        chk("rst_n", 32'(cluster_rst_no), 32'(e_rst));
        chk("iso", 32'(cluster_iso_o), 32'(e_iso));
        chk("ready", 32'(reg_ready_o), 32'(reg_valid_i));
        e_rd  = 32'd0;
        e_err = 1'b0;
        if (reg_valid_i) begin
            off   = int'(reg_addr_i[4:2]);
            e_err = (off > 4) || (reg_write_i && (off == 1 || off == 2));
            if (!reg_write_i) begin
                case (off)
                    0: e_rd = 32'(m_en);
                    1: e_rd = 32'(e_run);
                    2: e_rd = 32'(e_busy);
                    3: e_rd = {24'd0, m_delay};
                    4: e_rd = 32'(m_to);
                    default: e_rd = 32'd0;
                endcase
            end
        end
        chk("rdata", reg_rdata_o, e_rd);
        chk("error", 32'(reg_error_o), 32'(e_err));
    end

    task automatic rd(input int off, output logic [31:0] data, output logic err);
        reg_valid_i = 1'b1; reg_write_i = 1'b0;
        reg_addr_i  = 32'(off * 4); reg_wstrb_i = 4'h0; reg_wdata_i = 32'd0;
        @(negedge clk_i);
        data = reg_rdata_o; err = reg_error_o;
        @(posedge clk_i); #1;
        reg_valid_i = 1'b0;
    endtask

    task automatic wr(input int off, input logic [31:0] d, input logic [3:0] s, output logic err);
        reg_valid_i = 1'b1; reg_write_i = 1'b1;
        reg_addr_i  = 32'(off * 4); reg_wstrb_i = s; reg_wdata_i = d;
        @(negedge clk_i);
        err = reg_error_o;
        @(posedge clk_i); #1;
        reg_valid_i = 1'b0; reg_write_i = 1'b0;
    endtask

    function automatic logic sig_bit(input int sel, input int idx);
        case (sel)
            0:       return cluster_clk_en_o[idx];
            1:       return cluster_rst_no[idx];
            default: return cluster_iso_o[idx];
        endcase
    endfunction

    // Wait (bounded) until a cluster output has the given value; reports the edge.
    task automatic wait_sig(input string name, input int sel, input int idx,
                            input logic val, input int bound, output int at);
        at = -1;
        for (int k = 0; k <= bound; k++) begin
            if (sig_bit(sel, idx) === val) begin
                at = cyc;
                return;
            end
            @(posedge clk_i); #1;
        end
        n_checks++; n_fail++;
        $display("FAIL %s: no value %0b within %0d cycles (cycle %0d)", name, val, bound, cyc);
    endtask

    initial begin
        logic [31:0] v;
        logic        e;
        int          e0, t1, t2, ti;

        rst_ni = 1'b0; reg_valid_i = 1'b0; reg_write_i = 1'b0;
        reg_addr_i = '0; reg_wdata_i = '0; reg_wstrb_i = '0; cluster_idle_i = '0;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // reset state
        chk("rst_clk_en", 32'(cluster_clk_en_o), 32'h0);
        chk("rst_rst_n", 32'(cluster_rst_no), 32'h0);
        chk("rst_iso", 32'(cluster_iso_o), 32'h1F);
        rd(3, v, e); chk("rst_seq_delay", v, 32'd8);
        rd(1, v, e); chk("rst_status", v, 32'd0);

        // power-up, delay 4
        wr(3, 32'd4, 4'hF, e);
        wr(0, 32'h1, 4'hF, e); e0 = cyc;
        wait_sig("pu_clk", 0, 0, 1'b1, 20, t1);
        chk("pu_clk_latency", 32'(t1 - e0), 32'd1);
        wait_sig("pu_rst", 1, 0, 1'b1, 20, t2);
        chk("pu_rst_after_clk", 32'(t2 - t1), 32'd4);
        chk("pu_iso_released", 32'(cluster_iso_o[0]), 32'd0);
        rd(1, v, e); chk("pu_status", v, 32'h1);
        rd(2, v, e); chk("pu_busy", v, 32'h0);

        // power-down with idle three cycles after the write
        wr(0, 32'h0, 4'hF, e); e0 = cyc;
        wait_sig("pd_iso", 2, 0, 1'b1, 20, t1);
        chk("pd_iso_latency", 32'(t1 - e0), 32'd1);
        @(posedge clk_i); @(posedge clk_i); #1;
        cluster_idle_i[0] = 1'b1; ti = cyc;
        wait_sig("pd_rst", 1, 0, 1'b0, 20, t1);
        chk("pd_rst_after_idle", 32'(t1 - ti), 32'd1);
        wait_sig("pd_clk", 0, 0, 1'b0, 20, t2);
        chk("pd_clk_after_rst", 32'(t2 - t1), 32'd4);
        cluster_idle_i[0] = 1'b0;
        rd(1, v, e); chk("pd_status", v, 32'h0);

        // drain timeout with idle held low
        wr(0, 32'h1, 4'hF, e);
        wait_sig("to_up", 1, 0, 1'b1, 20, t1);
        wr(0, 32'h0, 4'hF, e); e0 = cyc;
        wait_sig("to_rst", 1, 0, 1'b0, 40, t1);
        chk("to_rst_latency", 32'(t1 - e0), 32'd17);
        rd(4, v, e); chk("to_sticky", v, 32'h1);
        wait_sig("to_off", 0, 0, 1'b0, 20, t2);
        chk("to_off_after_rst", 32'(t2 - t1), 32'd4);
        wr(4, 32'h1, 4'hF, e);
        rd(4, v, e); chk("to_cleared", v, 32'h0);

        // request withdrawn during CLKON: reaches RUN, then drains
        wr(0, 32'h4, 4'hF, e); e0 = cyc;
        @(posedge clk_i); #1;
        wr(0, 32'h0, 4'hF, e);
        wait_sig("tg_run", 1, 2, 1'b1, 20, t1);
        chk("tg_run_latency", 32'(t1 - e0), 32'd5);
        wait_sig("tg_drain", 2, 2, 1'b1, 20, t2);
        chk("tg_drain_after_run", 32'(t2 - t1), 32'd1);
        cluster_idle_i[2] = 1'b1;
        wait_sig("tg_off", 0, 2, 1'b0, 30, t1);
        cluster_idle_i[2] = 1'b0;

        // clusters 0 and 4 in one write
        wr(0, 32'h11, 4'hF, e); e0 = cyc;
        wait_sig("ls_rst0", 1, 0, 1'b1, 20, t1);
        wait_sig("ls_rst4", 1, 4, 1'b1, 20, t2);
        chk("ls_lat0", 32'(t1 - e0), 32'd5);
        chk("ls_lat4", 32'(t2 - e0), 32'd5);
        wr(0, 32'h0, 4'hF, e);
        cluster_idle_i = 5'h11;
        wait_sig("ls_off0", 0, 0, 1'b0, 30, t1);
        wait_sig("ls_off4", 0, 4, 1'b0, 30, t2);
        cluster_idle_i = '0;

        // SEQ_DELAY of zero acts as one
        wr(3, 32'h0, 4'hF, e);
        wr(0, 32'h2, 4'hF, e);
        wait_sig("z_clk", 0, 1, 1'b1, 20, t1);
        wait_sig("z_rst", 1, 1, 1'b1, 20, t2);
        chk("z_delay_one", 32'(t2 - t1), 32'd1);
        wr(0, 32'h0, 4'hF, e);
        cluster_idle_i[1] = 1'b1;
        wait_sig("z_off", 0, 1, 1'b0, 30, t1);
        cluster_idle_i[1] = 1'b0;

        // error and strobe handling
        rd(7, v, e); chk("err_unmapped_flag", 32'(e), 32'd1); chk("err_unmapped_data", v, 32'd0);
        wr(1, 32'h1F, 4'hF, e); chk("err_wr_status", 32'(e), 32'd1);
        wr(2, 32'h1F, 4'hF, e); chk("err_wr_busy", 32'(e), 32'd1);
        rd(0, v, e); chk("err_en_unchanged", v, 32'h0);
        chk("err_no_clk", 32'(cluster_clk_en_o), 32'h0);
        wr(0, 32'h1F, 4'h0, e);
        rd(0, v, e); chk("strb0_en", v, 32'h0);
        wr(0, 32'hFFFF_FFE0, 4'hF, e);
        rd(0, v, e); chk("high_bits_ignored", v, 32'h0);
        wr(3, 32'h0000_0506, 4'h2, e);
        rd(3, v, e); chk("strb_delay_byte1", v, 32'h0);
        wr(3, 32'h3, 4'hF, e);

        // randomized traffic against the model, with one async reset mid-run
        for (int k = 0; k < 2500; k++) begin
            for (int i = 0; i < N; i++)
                cluster_idle_i[i] = ($urandom_range(0, 99) < ((i == 3) ? 4 : 30));
            if ($urandom_range(0, 99) < 25 && k != 1500) begin
                reg_valid_i = 1'b1;
                reg_write_i = 1'($urandom_range(0, 1));
                reg_addr_i  = $urandom;
                reg_addr_i[4:2] = 3'($urandom_range(0, 7));
                reg_wdata_i = $urandom;
                if (reg_addr_i[4:2] == 3'd3) reg_wdata_i[7:0] = 8'($urandom_range(0, 6));
                reg_wstrb_i = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom_range(0, 15));
            end else begin
                reg_valid_i = 1'b0;
                reg_write_i = 1'b0;
            end
            if (k == 1500) rst_ni = 1'b0;
            @(posedge clk_i); #1;
            rst_ni = 1'b1;
        end
        reg_valid_i = 1'b0;
        @(posedge clk_i); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
